// File: rtl/sigmoid_8bit.sv
// Logistic sigmoid on a signed Q3.4 input, producing an unsigned Q0.8 probability.
// Two-stage pipeline: |x| and sign, then a 4-segment shift-and-add PLAN curve.
module sigmoid_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic signed [7:0] w_x;
  logic        [7:0] w_abs;
  logic        [8:0] w_p;
  logic        [7:0] w_y;
  logic              w_unused;

  logic              r_s_p1;
  logic        [7:0] r_a_p1;
  logic        [7:0] r_y_p2;

  // Positive-half curve; the result reaches 256 only in the flat top segment.
  function automatic logic [8:0] plan_p(input logic [7:0] a);
    if (a < 8'd16)
      plan_p = {a[6:0], 2'b00} + 9'd128;
    else if (a < 8'd38)
      plan_p = {a, 1'b0} + 9'd160;
    else if (a < 8'd80)
      plan_p = {2'b00, a[7:1]} + 9'd216;
    else
      plan_p = 9'd256;
  endfunction

  // Negative inputs mirror around 0.5; the positive side clips 256 down to 255.
  function automatic logic [7:0] sat_out(input logic s, input logic [8:0] p);
    if (!s)
      sat_out = p[8] ? 8'hFF : p[7:0];
    else
      sat_out = 8'(9'd256 - p);
  endfunction

  assign w_x      = ui_in;
  // Negating -128 wraps back to 0x80, which read as unsigned is exactly 128.
  assign w_abs    = w_x[7] ? 8'(-w_x) : 8'(w_x);
  assign w_p      = plan_p(r_a_p1);
  assign w_y      = sat_out(r_s_p1, w_p);
  assign w_unused = ^uio_in;

  // Stage 1: sign and magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_p1 <= 1'b0;
      r_a_p1 <= 8'h00;
    end else if (ena) begin
      r_s_p1 <= w_x[7];
      r_a_p1 <= w_abs;
    end
  end

  // Stage 2: piecewise-linear curve and sign folding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_y_p2 <= 8'h00;
    else if (ena)
      r_y_p2 <= w_y;
  end

  assign uo_out  = r_y_p2;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_sigmoid_8bit.sv
// Scoreboard bench for sigmoid_8bit: boundary points, stall, full sweep, mid-stream reset.
module tb_sigmoid_8bit;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int    n_checks;
  int    n_errors;
  int    q_exp[$];
  int    q_x[$];
  string q_tag[$];
  bit    sweep_on;
  int    prev_y;

  sigmoid_8bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_y(input int x);
    int a;
    int p;
    a = (x < 0) ? -x : x;
    if (a < 16)      p = 128 + a * 4;
    else if (a < 38) p = 160 + a * 2;
    else if (a < 80) p = 216 + a / 2;
    else             p = 256;
    if (x >= 0) return (p > 255) ? 255 : p;
    return 256 - p;
  endfunction

  function automatic int ideal_y(input int x);
    real r;
    int  v;
    r = 256.0 / (1.0 + $exp(-real'(x) / 16.0));
    v = $rtoi(r + 0.5);
    return (v > 255) ? 255 : v;
  endfunction

  // One clock with the given input; outputs checked #1 after the edge.
  task automatic step(input logic [7:0] x, input logic en, input string tag);
    int    e;
    int    xs;
    int    d;
    string t;
    ui_in = x;
    ena   = en;
    if (en) begin
      q_exp.push_back(model_y(int'($signed(x))));
      q_x.push_back(int'($signed(x)));
      q_tag.push_back(tag);
    end
    @(posedge clk);
    #1;
    if (en && q_exp.size() >= 2) begin
      e  = q_exp.pop_front();
      xs = q_x.pop_front();
      t  = q_tag.pop_front();
      chk(t, int'(uo_out), e);
      if (sweep_on) begin
        chk("mono", int'(int'(uo_out) >= prev_y), 1);
        d = int'(uo_out) - ideal_y(xs);
        chk("approx", int'(d <= 6 && d >= -6), 1);
        prev_y = int'(uo_out);
      end
    end
  endtask

  initial begin
    logic [7:0] pos_in [7];
    logic [7:0] neg_in [6];
    n_checks = 0;
    n_errors = 0;
    sweep_on = 1'b0;
    prev_y   = -1;
    uio_in   = 8'hA5;
    ena      = 1'b0;
    ui_in    = 8'h40;
    rst_n    = 1'b0;

    // Reset holds the output at zero with no clock edge yet.
    #2;
    chk("rst_async", int'(uo_out), 0);
    chk("uio_out", int'(uio_out), 0);
    chk("uio_oe", int'(uio_oe), 0);
    @(posedge clk);
    #1;
    chk("rst_hold", int'(uo_out), 0);
    #3;
    rst_n = 1'b1;
    ui_in = 8'h00;
    step(8'h00, 1'b1, "zero");
    chk("post_rst1", int'(uo_out), 128);
    step(8'h00, 1'b1, "zero");
    chk("zero_0x80", int'(uo_out), 128);

    pos_in = '{8'h0F, 8'h10, 8'h25, 8'h26, 8'h4F, 8'h50, 8'h7F};
    neg_in = '{8'hFF, 8'hF0, 8'hDA, 8'hB1, 8'hB0, 8'h80};
    foreach (pos_in[i]) step(pos_in[i], 1'b1, "pos_seg");
    foreach (neg_in[i]) step(neg_in[i], 1'b1, "neg_seg");
    chk("uio_out_run", int'(uio_out), 0);
    chk("uio_oe_run", int'(uio_oe), 0);

    // Stall: 192 must be held while ena is low.
    step(8'h10, 1'b1, "stall_a");
    step(8'h10, 1'b1, "stall_a");
    chk("stall_pre", int'(uo_out), 192);
    for (int i = 0; i < 3; i++) begin
      step(8'h5A, 1'b0, "idle");
      chk("stall_hold", int'(uo_out), 192);
    end
    step(8'hF0, 1'b1, "stall_b");
    step(8'h00, 1'b1, "stall_c");
    chk("stall_out", int'(uo_out), 64);

    // Full sweep in signed order.
    step(8'h80, 1'b1, "sweep");
    sweep_on = 1'b1;
    prev_y   = -1;
    for (int x = -127; x < 128; x++) step(8'(x), 1'b1, "sweep");
    step(8'h7F, 1'b1, "sweep");
    sweep_on = 1'b0;

    // Mid-stream reset between edges discards in-flight samples.
    step(8'h30, 1'b1, "pre_rst");
    step(8'hE0, 1'b1, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", int'(uo_out), 0);
    q_exp.delete();
    q_x.delete();
    q_tag.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_hold", int'(uo_out), 0);
    #3;
    rst_n = 1'b1;
    step(8'hC8, 1'b1, "post_rst");
    chk("post_rst_first", int'(uo_out), 128);
    step(8'h08, 1'b1, "post_rst");
    step(8'h40, 1'b1, "post_rst");
    step(8'h00, 1'b1, "drain");
    step(8'h00, 1'b1, "drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
